// File: rtl/shared_burst_scheduler.sv
// Round-robin burst scheduler: grants one of three requesters a shared resource
// for a whole multi-beat burst, with a one-cycle idle bubble between grants.
module shared_burst_scheduler #(
    parameter int unsigned LEN_W = 4
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 en,
    input  logic [2:0]           req_vld,
    input  logic [3*LEN_W-1:0]   req_len,
    input  logic                 beat_done,
    output logic [2:0]           o_grant,
    output logic                 o_start,
    output logic                 o_last,
    output logic                 o_busy
);

    localparam int unsigned N_REQ = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [LEN_W-1:0]    cnt;
    logic [LEN_W-1:0]    cnt_nxt;
    logic [2:0]          last_grant;
    logic [2:0]          last_grant_nxt;
    logic [2:0]          grant_nxt;
    logic                start_nxt;
    logic                last_nxt;
    logic                busy_nxt;

    logic [1:0]          win_idx;
    logic [2:0]          win_onehot;
    logic [LEN_W-1:0]    win_len;

    // Search starts just after the previous winner and wraps around.
    function automatic logic [1:0] pick_idx(input logic [2:0] req, input logic [2:0] last);
        logic [1:0] first;
        logic [1:0] idx;
        logic       found;
        case (last)
            3'b001:  first = 2'd1;
            3'b010:  first = 2'd2;
            default: first = 2'd0;
        endcase
        pick_idx = first;
        found    = 1'b0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            idx = 2'((32'(first) + off) % N_REQ);
            if (!found && req[idx]) begin
                pick_idx = idx;
                found    = 1'b1;
            end
        end
    endfunction

    always_comb begin
        win_idx    = pick_idx(req_vld, last_grant);
        win_onehot = 3'b001 << win_idx;
        win_len    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win_idx == 2'(i)) begin
                win_len = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        last_grant_nxt = last_grant;
        grant_nxt      = o_grant;
        start_nxt      = 1'b0;

        case (state)
            IDLE: begin
                grant_nxt = '0;
                if (en && (|req_vld)) begin
                    grant_nxt      = win_onehot;
                    last_grant_nxt = win_onehot;
                    cnt_nxt        = win_len;
                    start_nxt      = 1'b1;
                    state_nxt      = BURST;
                end
            end
            BURST: begin
                if (beat_done) begin
                    if (cnt == '0) begin
                        grant_nxt = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt - LEN_W'(1);
                    end
                end
            end
            default: begin
                grant_nxt = '0;
                state_nxt = IDLE;
            end
        endcase

        // o_last/o_busy are registered copies of their defining condition one cycle ahead.
        busy_nxt = (state_nxt == BURST);
        last_nxt = (state_nxt == BURST) && (cnt_nxt == '0);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 3'b100;
            o_grant    <= '0;
            o_start    <= 1'b0;
            o_last     <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last_grant <= last_grant_nxt;
            o_grant    <= grant_nxt;
            o_start    <= start_nxt;
            o_last     <= last_nxt;
            o_busy     <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_shared_burst_scheduler.sv
// Directed plus randomized bench for shared_burst_scheduler against a
// cycle-level behavioural model of the grant/burst rules.
module tb_shared_burst_scheduler;

    localparam int unsigned LEN_W = 4;
    localparam int          N     = 3;

    logic                 clk;
    logic                 srst;
    logic                 en;
    logic [2:0]           req_vld;
    logic [3*LEN_W-1:0]   req_len;
    logic                 beat_done;
    logic [2:0]           o_grant;
    logic                 o_start;
    logic                 o_last;
    logic                 o_busy;

    int n_checks;
    int n_pass;

    // Reference model state: who owns the resource and how many beats remain after this one.
    bit m_busy;
    bit m_start;
    int m_idx;
    int m_rem;
    int m_last_idx;

    shared_burst_scheduler #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .srst      (srst),
        .en        (en),
        .req_vld   (req_vld),
        .req_len   (req_len),
        .beat_done (beat_done),
        .o_grant   (o_grant),
        .o_start   (o_start),
        .o_last    (o_last),
        .o_busy    (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int len_of(input int i);
        return int'((req_len >> (i * int'(LEN_W))) & ((1 << LEN_W) - 1));
    endfunction

    task automatic model_step();
        if (srst) begin
            m_busy     = 0;
            m_start    = 0;
            m_idx      = 0;
            m_rem      = 0;
            m_last_idx = 2;
        end else if (!m_busy) begin
            m_start = 0;
            if (en && req_vld != 3'b000) begin
                for (int off = 1; off <= N; off++) begin
                    int i;
                    i = (m_last_idx + off) % N;
                    if (!m_busy && req_vld[i]) begin
                        m_busy     = 1;
                        m_start    = 1;
                        m_idx      = i;
                        m_last_idx = i;
                        m_rem      = len_of(i);
                    end
                end
            end
        end else begin
            m_start = 0;
            if (beat_done) begin
                if (m_rem == 0) m_busy = 0;
                else            m_rem  = m_rem - 1;
            end
        end
    endtask

    task automatic compare();
        logic [2:0] e_grant;
        e_grant = m_busy ? 3'(1 << m_idx) : 3'b000;
        check("grant", 32'(o_grant), 32'(e_grant));
        check("start", 32'(o_start), 32'(m_start));
        check("last",  32'(o_last),  32'(m_busy && m_rem == 0));
        check("busy",  32'(o_busy),  32'(m_busy));
        check("inv_onehot", 32'($countones(o_grant) <= 1), 32'd1);
        check("inv_busy_grant", 32'(o_busy), 32'(|o_grant));
        check("inv_last_busy", 32'(!o_last || o_busy), 32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic drain();
        int n;
        en        = 1'b0;
        beat_done = 1'b1;
        n = 0;
        while (o_busy && n < 60) begin
            tick();
            n++;
        end
        check("drain_idle", 32'(o_busy), 32'd0);
    endtask

    initial begin
        logic [2:0] seq [8];
        logic [2:0] exp_seq [8];
        int gcnt, scnt, spos, lcnt, lpos, l7;

        n_checks = 0;
        n_pass   = 0;
        srst = 1'b1; en = 1'b0; req_vld = '0; req_len = '0; beat_done = 1'b0;
        m_busy = 0; m_start = 0; m_idx = 0; m_rem = 0; m_last_idx = 2;

        // Reset, with other inputs active to show reset wins.
        tick();
        en = 1'b1; req_vld = 3'b111; beat_done = 1'b1;
        tick();
        check("rst_grant", 32'(o_grant), 32'd0);
        check("rst_busy",  32'(o_busy),  32'd0);

        // Round-robin with single-beat bursts.
        srst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            seq[k] = o_grant;
        end
        exp_seq = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
        for (int k = 0; k < 8; k++) check($sformatf("rr_seq%0d", k), 32'(seq[k]), 32'(exp_seq[k]));

        // Four-beat burst on requester 1, beats on alternate cycles, inputs disturbed mid-burst.
        drain();
        en = 1'b1; req_vld = 3'b010; req_len = 12'h030; beat_done = 1'b0;
        tick();
        gcnt = 0; scnt = 0; spos = 0; lcnt = 0; lpos = 0; l7 = 0;
        for (int k = 1; k <= 8; k++) begin
            if (o_grant == 3'b010) gcnt++;
            if (o_start) begin scnt++; spos = k; end
            if (o_last) begin lcnt++; lpos = k; if (k == 7) l7 = 1; end
            beat_done = (k % 2 == 0);
            if (k == 2) begin req_vld = 3'b101; en = 1'b0; req_len = '0; end
            tick();
        end
        check("b4_grant_cycles", 32'(gcnt), 32'd8);
        check("b4_start_cnt", 32'(scnt), 32'd1);
        check("b4_start_pos", 32'(spos), 32'd1);
        check("b4_last_cnt", 32'(lcnt), 32'd2);
        check("b4_last_c7", 32'(l7), 32'd1);
        check("b4_last_pos", 32'(lpos), 32'd8);
        check("b4_end_grant", 32'(o_grant), 32'd0);
        tick();
        tick();
        check("en0_no_grant", 32'(o_grant), 32'd0);
        en = 1'b1;
        tick();
        check("rr_after_010", 32'(o_grant), 32'b100);

        // Maximum-length burst.
        drain();
        en = 1'b1; req_vld = 3'b001; req_len = 12'h00F; beat_done = 1'b1;
        gcnt = 0; lcnt = 0; lpos = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (o_grant == 3'b001) begin
                gcnt++;
                if (o_last) begin lcnt++; lpos = gcnt; end
            end else if (gcnt > 0) begin
                break;
            end
        end
        check("max_grant_cycles", 32'(gcnt), 32'd16);
        check("max_last_cnt", 32'(lcnt), 32'd1);
        check("max_last_pos", 32'(lpos), 32'd16);
        check("max_end_grant", 32'(o_grant), 32'd0);

        // Reset during the third cycle of a burst.
        drain();
        en = 1'b1; req_vld = 3'b111; req_len = 12'h777; beat_done = 1'b0;
        tick();
        tick();
        tick();
        check("pre_rst_busy", 32'(o_busy), 32'd1);
        srst = 1'b1;
        tick();
        check("mid_rst_grant", 32'(o_grant), 32'd0);
        check("mid_rst_busy",  32'(o_busy),  32'd0);
        srst = 1'b0;
        tick();
        check("post_rst_grant", 32'(o_grant), 32'b001);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            srst      = ($urandom_range(0, 79) == 0);
            en        = ($urandom_range(0, 3) != 0);
            req_vld   = 3'($urandom);
            req_len   = 12'($urandom);
            beat_done = 1'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
